// File: rtl/timing_control.sv
// timing_control: sequence counter, T-state decoder and S/IEN/R control flip-flops
module timing_control #(
    parameter int SC_WIDTH = 4,
    parameter int NUM_T    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                hlt,
    input  logic                sc_clr,
    input  logic                ion,
    input  logic                iof,
    input  logic                fgi,
    input  logic                fgo,
    output logic [NUM_T-1:0]    t,
    output logic [SC_WIDTH-1:0] sc_value,
    output logic                s_out,
    output logic                ien_out,
    output logic                r_out
);
    logic [SC_WIDTH-1:0] r_sc;
    logic                r_s;
    logic                r_ien;
    logic                r_r;
    logic                w_rt2;
    logic                w_r_set;
    logic [SC_WIDTH-1:0] w_sc_next;
    logic                w_ien_next;

    // R.T2 is the last interrupt-cycle state; it overrides sc_clr and ion/iof
    assign w_rt2   = r_r && (r_sc == SC_WIDTH'(2));
    assign w_r_set = !r_r && r_s && (r_sc > SC_WIDTH'(2)) && r_ien && (fgi || fgo);

    // next-state selection for SC and IEN, highest priority first
    always_comb begin
        w_sc_next  = w_rt2 ? '0 : sc_clr ? '0 : r_s ? r_sc + SC_WIDTH'(1) : r_sc;
        w_ien_next = w_rt2 ? 1'b0 : r_r ? r_ien : iof ? 1'b0 : ion ? 1'b1 : r_ien;
    end

    // control state registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sc  <= '0;
            r_s   <= 1'b0;
            r_ien <= 1'b0;
            r_r   <= 1'b0;
        end else begin
            r_sc  <= w_sc_next;
            r_s   <= hlt ? 1'b0 : start ? 1'b1 : r_s;
            r_ien <= w_ien_next;
            r_r   <= w_rt2 ? 1'b0 : w_r_set ? 1'b1 : r_r;
        end
    end

    assign t        = NUM_T'(1) << r_sc;
    assign sc_value = r_sc;
    assign s_out    = r_s;
    assign ien_out  = r_ien;
    assign r_out    = r_r;
endmodule
